sha256_msg_sched: RTL
=====================

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 64, total schedule words emitted per block; legal range 17..64.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, begins a new block; sampled only in IDLE.
REQ-005 SHALL have port in_valid_i, input, 1, message word valid.
REQ-006 SHALL have port in_data_i, input, 32, message word M[j], big-endian word order j=0..15.
REQ-007 SHALL have port in_ready_o, output, 1, word accepted when in_valid_i && in_ready_o.
REQ-008 SHALL have port w_valid_o, output, 1, schedule word valid.
REQ-009 SHALL have port w_data_o, output, 32, schedule word W[t].
REQ-010 SHALL have port w_idx_o, output, 6, round index t of w_data_o.
REQ-011 SHALL have port w_ready_i, input, 1, consumer accepts when w_valid_o && w_ready_i.
REQ-012 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done_o, output, 1, one-cycle pulse after word NUM_ROUNDS-1 is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, EMIT, with a 16x32 window register win[0..15] (win[0] oldest) and a 6-bit counter cnt.
REQ-015 IDLE: in_ready_o=0, w_valid_o=0; start_i=1 -> LOAD with cnt=0 on the next edge.
REQ-016 LOAD: in_ready_o=1; each accepted word is written to win[cnt], cnt++; the 16th acceptance -> EMIT with cnt=0.
REQ-017 EMIT, t=cnt<16: w_valid_o=1, w_data_o=win[t], window unchanged on acceptance.
REQ-018 EMIT, t>=16: w_data_o = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0] mod 2^32; sigma0 = ROTR7^ROTR18^SHR3, sigma1 = ROTR17^ROTR19^SHR10.
REQ-019 On acceptance with t>=16, window SHALL shift (win[i]<=win[i+1], win[15]<=w_data_o) in the same edge.
REQ-020 w_idx_o SHALL equal cnt during EMIT and 0 otherwise.
REQ-021 Word NUM_ROUNDS-1 accepted -> IDLE; done_o=1 for exactly that following cycle.
REQ-022 While w_valid_o=1 and w_ready_i=0, w_data_o and w_idx_o SHALL hold stable (window and cnt frozen).
REQ-023 Throughput SHALL be one word per cycle when w_ready_i=1; first word valid the cycle after the 16th input acceptance.
REQ-024 start_i in LOAD or EMIT SHALL be ignored; in_valid_i outside LOAD SHALL be ignored.
REQ-025 Combinational paths: w_data_o SHALL NOT depend on w_ready_i; in_ready_o SHALL depend only on state.

Reset
REQ-026 rst_i=1 SHALL force state=IDLE, cnt=0, win all 0, in_ready_o=0, w_valid_o=0, busy_o=0, done_o=0, w_idx_o=0, w_data_o=0 immediately.
REQ-027 Reset asserted mid-LOAD or mid-EMIT SHALL abandon the block; no done_o pulse.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding constants, the word width (32), the window depth (16), and the sigma0/sigma1 rotate/shift amounts.
REQ-029 The expansion adder SHALL be one sub-module, the team's existing M32 word-expansion block, instantiated once with a=win[0], b=win[14], c=win[9], d=win[1].
REQ-030 The block SHALL NOT register the expansion output; one 4-operand add per cycle is the critical path.

Verification
REQ-031 "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready_i=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB; done_o one pulse.
REQ-032 Same block, w_ready_i toggled pseudo-randomly -> identical 64-word sequence; data and idx stable during every stall.
REQ-033 in_valid_i gaps of 0..3 cycles during LOAD -> exactly 16 words taken; first output W0=0x61626380, idx 0.
REQ-034 rst_i pulsed while idx=40 -> outputs zero at once; a fresh start_i+"abc" block reproduces REQ-031 values.
REQ-035 start_i held high through EMIT -> no restart; after done_o, the still-high start_i starts a new LOAD.
REQ-036 NUM_ROUNDS=20 build -> words 0..19 emitted, done_o after idx 19, return to IDLE.

Source files
------------

// File: rtl/sha256_msg_sched_pkg.sv
// sha256_msg_sched_pkg: shared widths, FSM encoding and sigma rotate/shift amounts for the message scheduler.
package sha256_msg_sched_pkg;
  localparam int WORD_W = 32;
  localparam int WIN_DEPTH = 16;
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_EMIT = 2'd2} state_e;
  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
  function automatic word_t sigma0(input word_t x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction
  function automatic word_t sigma1(input word_t x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction
endpackage

// File: rtl/sha256_msg_sched_m32.sv
// sha256_msg_sched_m32: combinational word expansion y = sigma1(b) + c + sigma0(d) + a mod 2^32.
module sha256_msg_sched_m32
  import sha256_msg_sched_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] y
);
  assign y = sigma1(b) + c + sigma0(d) + a;
endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: loads 16 message words, then streams NUM_ROUNDS schedule words with valid/ready.
module sha256_msg_sched
  import sha256_msg_sched_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              w_valid_o,
  output logic [WORD_W-1:0] w_data_o,
  output logic [5:0]        w_idx_o,
  input  logic              w_ready_i,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  word_t win_q [WIN_DEPTH];
  word_t win_d [WIN_DEPTH];
  logic done_q, done_d;
  word_t exp_w;
  logic in_acc, w_acc;
  sha256_msg_sched_m32 u_m32 (
    .a(win_q[0]),
    .b(win_q[14]),
    .c(win_q[9]),
    .d(win_q[1]),
    .y(exp_w)
  );
  assign in_ready_o = state_q == ST_LOAD;
  assign w_valid_o  = state_q == ST_EMIT;
  assign busy_o     = state_q != ST_IDLE;
  assign done_o     = done_q;
  assign w_idx_o    = w_valid_o ? cnt_q : '0;
  // The first 16 rounds replay the loaded window; later rounds use the unregistered expansion.
  assign w_data_o   = !w_valid_o ? '0 : (cnt_q < 6'd16) ? win_q[cnt_q[3:0]] : exp_w;
  assign in_acc     = in_ready_o && in_valid_i;
  assign w_acc      = w_valid_o && w_ready_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE && start_i) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end
    if (in_acc) begin
      win_d[cnt_q[3:0]] = in_data_i;
      cnt_d   = (cnt_q == 6'd15) ? '0 : cnt_q + 6'd1;
      state_d = (cnt_q == 6'd15) ? ST_EMIT : ST_LOAD;
    end
    if (w_acc) begin
      if (cnt_q >= 6'd16) begin
        for (int i = 0; i < WIN_DEPTH - 1; i++) win_d[i] = win_q[i+1];
        win_d[WIN_DEPTH-1] = exp_w;
      end
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 6'd1;
      state_d = (cnt_q == LAST) ? ST_IDLE : ST_EMIT;
      done_d  = cnt_q == LAST;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= '{default: '0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      done_q  <= done_d;
    end
  end
endmodule
